// File: rtl/scan_sequencer.sv
// Scan-path sequencer: shifts a latched word LSB-first into the DUT scan chain with a
// programmable half-period scan clock while capturing scan-out into rx_data_o.
module scan_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned HP_W   = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  shift_len_i,
  input  logic [HP_W-1:0]   half_period_i,
  input  logic              hold_en_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic [CNT_W-1:0]  bit_count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              dut_scan_en_o,
  output logic              dut_scan_clk_o,
  output logic              dut_scan_in_o,
  input  logic              dut_scan_out_i
);

  typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

  localparam logic [CNT_W-1:0] MaxLen = CNT_W'(DATA_W);

  state_e            state_q;
  logic [DATA_W-1:0] tx_q, rx_q;
  logic [CNT_W-1:0]  len_q, bit_count_q;
  logic [HP_W-1:0]   hp_q, phase_q;
  logic              hold_q, busy_q, done_q, scan_en_q, scan_clk_q, scan_in_q;

  logic [CNT_W-1:0]  len_eff, bit_next;
  logic [HP_W-1:0]   hp_eff;
  logic              phase_end, next_tx_bit;

  always_comb begin
    len_eff = shift_len_i;
    if (shift_len_i == '0 || shift_len_i > MaxLen) begin
      len_eff = MaxLen;
    end
    hp_eff = (half_period_i == '0) ? HP_W'(1) : half_period_i;
    bit_next = bit_count_q + CNT_W'(1);
    phase_end = (phase_q == hp_q - HP_W'(1));
    // Mask-and-reduce keeps every tx bit in use and avoids a variable-width index.
    next_tx_bit = |(tx_q & (DATA_W'(1) << bit_next));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      tx_q        <= '0;
      rx_q        <= '0;
      len_q       <= '0;
      bit_count_q <= '0;
      hp_q        <= '0;
      phase_q     <= '0;
      hold_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      scan_en_q   <= 1'b0;
      scan_clk_q  <= 1'b0;
      scan_in_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q    <= StIdle;
        busy_q     <= 1'b0;
        scan_clk_q <= 1'b0;
        scan_en_q  <= 1'b0;
        phase_q    <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_i) begin
              tx_q        <= tx_data_i;
              len_q       <= len_eff;
              hp_q        <= hp_eff;
              hold_q      <= hold_en_i;
              rx_q        <= '0;
              bit_count_q <= '0;
              phase_q     <= '0;
              busy_q      <= 1'b1;
              scan_en_q   <= 1'b1;
              scan_clk_q  <= 1'b0;
              scan_in_q   <= tx_data_i[0];
              state_q     <= StLow;
            end
          end
          StLow: begin
            if (phase_end) begin
              // Capture scan-out as it stands just before the rising scan edge.
              rx_q       <= rx_q | (DATA_W'(dut_scan_out_i) << bit_count_q);
              scan_clk_q <= 1'b1;
              phase_q    <= '0;
              state_q    <= StHigh;
            end else begin
              phase_q <= phase_q + HP_W'(1);
            end
          end
          StHigh: begin
            if (phase_end) begin
              bit_count_q <= bit_next;
              scan_clk_q  <= 1'b0;
              phase_q     <= '0;
              if (bit_next < len_q) begin
                scan_in_q <= next_tx_bit;
                state_q   <= StLow;
              end else begin
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                scan_en_q <= hold_q;
                state_q   <= StIdle;
              end
            end else begin
              phase_q <= phase_q + HP_W'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rx_data_o      = rx_q;
  assign bit_count_o    = bit_count_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign dut_scan_en_o  = scan_en_q;
  assign dut_scan_clk_o = scan_clk_q;
  assign dut_scan_in_o  = scan_in_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: a shift-register chain model on the scan pins and a queue-based
// reference computing expected capture, chain contents and waveform timing per burst.
module tb_scan_sequencer;

  logic        clk, reset, start, abort, hold_en;
  logic [4:0]  shift_len;
  logic [7:0]  half_period;
  logic [15:0] tx_data, rx_data;
  logic [4:0]  bit_count;
  logic        busy, done, scan_en, scan_clk, scan_in, scan_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Environment chain: bit 0 feeds scan_out, scan_in enters at the top on each rising scan edge.
  logic [15:0] chain, chain_load_val, ch_tmp;
  logic        chain_load;
  int          chain_len;

  scan_sequencer #(.DATA_W(16), .CNT_W(5), .HP_W(8)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (start),
    .abort_i        (abort),
    .shift_len_i    (shift_len),
    .half_period_i  (half_period),
    .hold_en_i      (hold_en),
    .tx_data_i      (tx_data),
    .rx_data_o      (rx_data),
    .bit_count_o    (bit_count),
    .busy_o         (busy),
    .done_o         (done),
    .dut_scan_en_o  (scan_en),
    .dut_scan_clk_o (scan_clk),
    .dut_scan_in_o  (scan_in),
    .dut_scan_out_i (scan_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge scan_clk or posedge chain_load) begin
    if (chain_load) begin
      chain <= chain_load_val;
    end else begin
      ch_tmp = chain >> 1;
      ch_tmp[chain_len-1] = scan_in;
      chain <= ch_tmp;
    end
  end
  assign scan_out = chain[0];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic preload_chain(input logic [15:0] val, input int len);
    chain_len      = len;
    chain_load_val = val;
    chain_load     = 1'b1;
    #1;
    chain_load     = 1'b0;
  endtask

  task automatic run_burst(input logic [15:0] tx, input int len, input int hp, input logic hold,
                           input bit noise, input int abort_at, input string tag);
    int l_eff, h_eff, n_cap, n_bits, limit, busy_cnt, done_cnt, done_j, rises, rise_err, in_err;
    logic prev_clk, prev_in, en_at_done;
    logic q[$];
    logic [15:0] exp_rx, exp_chain;

    l_eff = (len == 0 || len > 16) ? 16 : len;
    h_eff = (hp == 0) ? 1 : hp;
    if (abort_at < 0) begin
      n_cap  = l_eff;
      n_bits = l_eff;
      limit  = 2 * h_eff * l_eff + 3;
    end else begin
      n_cap  = 0;
      n_bits = 0;
      for (int k = 0; k < l_eff; k++) begin
        if ((2 * k + 1) * h_eff <= abort_at) n_cap++;
        if ((2 * k + 2) * h_eff <= abort_at) n_bits++;
      end
      limit = abort_at + 4;
    end

    q.delete();
    for (int i = 0; i < chain_len; i++) q.push_back(chain[i]);
    exp_rx = '0;
    for (int k = 0; k < n_cap; k++) begin
      exp_rx[k] = q.pop_front();
      q.push_back(tx[k]);
    end
    exp_chain = '0;
    for (int i = 0; i < chain_len; i++) exp_chain[i] = q[i];

    @(negedge clk);
    tx_data     = tx;
    shift_len   = len[4:0];
    half_period = hp[7:0];
    hold_en     = hold;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    tx_data     = 16'($urandom);
    shift_len   = 5'($urandom);
    half_period = 8'($urandom);
    hold_en     = 1'($urandom);

    busy_cnt = 0; done_cnt = 0; done_j = -1; rises = 0; rise_err = 0; in_err = 0;
    prev_clk = 1'b0; prev_in = tx[0]; en_at_done = 1'b0;
    for (int j = 0; j <= limit; j++) begin
      @(negedge clk);
      if (j == 0) check_eq({tag, "/issue"}, {busy, scan_en, scan_clk, scan_in},
                           {1'b1, 1'b1, 1'b0, tx[0]});
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_j < 0) begin
          done_j     = j;
          en_at_done = scan_en;
        end
      end
      if (scan_clk && !prev_clk) begin
        if (j != (2 * rises + 1) * h_eff || scan_in !== tx[rises] || prev_in !== scan_in)
          rise_err++;
        rises++;
      end
      if (scan_in !== prev_in && (scan_clk || (j % (2 * h_eff)) != 0)) in_err++;
      if (abort_at >= 0 && j == abort_at + 1)
        check_eq({tag, "/abort_next"}, {busy, scan_en, scan_clk, done}, 4'b0000);
      prev_clk = scan_clk;
      prev_in  = scan_in;
      start = noise && (j < 2 * h_eff * l_eff - 2) && (j % 2 == 1);
      abort = (j == abort_at);
    end
    start = 1'b0;
    abort = 1'b0;

    if (abort_at < 0) begin
      check_eq({tag, "/busy_cycles"}, busy_cnt, 2 * h_eff * l_eff);
      check_eq({tag, "/done_cycle"}, done_j, 2 * h_eff * l_eff);
      check_eq({tag, "/done_count"}, done_cnt, 1);
      check_eq({tag, "/en_at_done"}, en_at_done, hold);
      check_eq({tag, "/en_after"}, scan_en, hold);
    end else begin
      check_eq({tag, "/busy_cycles"}, busy_cnt, abort_at + 1);
      check_eq({tag, "/done_count"}, done_cnt, 0);
      check_eq({tag, "/en_after"}, scan_en, 0);
    end
    check_eq({tag, "/rises"}, rises, n_cap);
    check_eq({tag, "/rise_timing"}, rise_err, 0);
    check_eq({tag, "/scan_in_changes"}, in_err, 0);
    check_eq({tag, "/rx_data"}, rx_data, exp_rx);
    check_eq({tag, "/bit_count"}, bit_count, n_bits);
    check_eq({tag, "/chain"}, chain, exp_chain);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; hold_en = 1'b0;
    shift_len = '0; half_period = '0; tx_data = '0;
    chain_load = 1'b0; chain_load_val = '0; ch_tmp = '0;
    preload_chain(16'h0000, 16);
    #3;
    check_eq("reset_outputs", {rx_data, bit_count, busy, done, scan_en, scan_clk, scan_in}, '0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Loopback through a 4-bit chain
    preload_chain(16'h0005, 4);
    run_burst(16'h000A, 4, 1, 1'b0, 1'b0, -1, "loop4");
    check_eq("loop4/rx_const", rx_data, 16'h0005);
    check_eq("loop4/chain_const", chain, 16'h000A);

    // Clamping of L=0 and H=0, then a 16-bit loopback of the previous contents
    preload_chain(16'($urandom), 16);
    run_burst(16'hBEEF, 0, 0, 1'b0, 1'b0, -1, "clamp");
    check_eq("clamp/bit_count16", bit_count, 16);
    run_burst(16'($urandom), 16, 1, 1'b0, 1'b0, -1, "loop16");
    check_eq("loop16/rx_const", rx_data, 16'hBEEF);

    run_burst(16'($urandom), 2, 5, 1'b0, 1'b0, -1, "phase");
    run_burst(16'($urandom), 8, 1, 1'b0, 1'b0, 6, "abort");
    check_eq("abort/bit_count3", bit_count, 3);

    // Hold, start ignored while busy, abort+start in idle
    run_burst(16'($urandom), 5, 2, 1'b1, 1'b1, -1, "hold1");
    @(negedge clk);
    start = 1'b1; abort = 1'b1; shift_len = 5'd4; half_period = 8'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start/next", {busy, scan_en, scan_clk}, 3'b000);
    repeat (3) @(negedge clk);
    check_eq("abort_start/idle", {busy, done, scan_en}, 3'b000);
    run_burst(16'($urandom), 3, 1, 1'b1, 1'b1, -1, "hold2");
    run_burst(16'($urandom), 4, 2, 1'b0, 1'b1, -1, "hold0");

    // Reset mid-burst
    @(negedge clk);
    tx_data = 16'($urandom); shift_len = 5'd8; half_period = 8'd3; hold_en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check_eq("rst_mid/busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("rst_mid/outputs", {rx_data, bit_count, busy, done, scan_en, scan_clk, scan_in}, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_burst(16'($urandom), 3, 2, 1'b0, 1'b0, -1, "post_rst");

    for (int i = 0; i < 14; i++) begin
      int l, h, ab, le;
      bit nz;
      l  = $urandom_range(0, 20);
      h  = $urandom_range(0, 3);
      le = (l == 0 || l > 16) ? 16 : l;
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, 2 * ((h == 0) ? 1 : h) * le - 1);
      nz = (ab < 0) && ($urandom_range(0, 1) == 1);
      run_burst(16'($urandom), l, h, 1'($urandom), nz, ab, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
